fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
Round-robin arbiter that shares a single fifo_sync write port between NUM_REQ ready/valid requesters. Arbitration is burst-locked: a granted requester holds the port until its last beat, or until MAX_BURST beats, whichever comes first. The block sits directly in front of the shared FIFO input: out_valid/out_ready/out_data connect to in_valid/in_ready/in_data. out_src is stored alongside the data word as a sideband.

Parameters:
NUM_REQ, 4, number of requesters; any value >= 2, need not be a power of 2.
WIDTH, 32, data beat width.
MAX_BURST, 8, maximum beats per grant; must be >= 1.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  NUM_REQ  per-requester beat valid.
req_ready  output  NUM_REQ  per-requester beat accepted.
req_data  input  NUM_REQ*WIDTH  packed requester data; requester i occupies bits [i*WIDTH +: WIDTH].
req_last  input  NUM_REQ  final beat of the requester's burst.
out_valid  output  1  beat valid toward the FIFO.
out_ready  input  1  FIFO ready (FIFO not full).
out_data  output  WIDTH  granted requester's data.
out_last  output  1  granted requester's last flag.
out_src  output  max(1,$clog2(NUM_REQ))  index of the granted requester.
grant_active  output  1  high while in BURST.
burst_err  output  1  one-cycle pulse on a forced release without last.

Behaviour:
- Reset state and outputs: state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0. All of out_valid, req_ready, grant_active and burst_err are 0. out_src=0, out_data=0, out_last=0.
- FSM states: IDLE and BURST.
- IDLE arbitration:
  - If any req_valid is high, search indices rr_ptr, rr_ptr+1, ..., wrapping from NUM_REQ-1 to 0, and pick the first requester with req_valid high.
  - Register that index as grant_idx, clear beat_cnt, and move to BURST on the next edge.
  - Arbitration costs exactly 1 idle cycle per grant.
  - In IDLE, out_valid=0 and all req_ready=0. No beat transfers.
- BURST data path, combinational from grant_idx:
  - out_valid = req_valid[grant_idx]; out_data, out_last and out_src follow grant_idx.
  - req_ready[grant_idx] = out_ready. All other req_ready bits are 0.
  - out_data, out_last and out_src hold grant_idx values even when out_valid=0.
- Beat accept: out_valid && out_ready. On each accepted beat, beat_cnt increments.
- Burst end, on an accepted beat:
  - Release happens when req_last=1 or beat_cnt==MAX_BURST-1.
  - On release: next state=IDLE, rr_ptr = grant_idx+1 (wrapping to 0 after NUM_REQ-1), beat_cnt=0.
  - If release was forced by MAX_BURST while req_last=0, burst_err pulses high for the following cycle.
  - The requester continues its packet in a later grant; the arbiter keeps no per-packet state.
- Valid gaps: if req_valid[grant_idx] drops mid-burst, the grant is held indefinitely. No timeout, and no other requester is served.
- Backpressure: out_ready=0 stalls the beat. The beat is not counted and req_ready stays 0.
- MAX_BURST=1: every accepted beat releases the grant. burst_err pulses whenever last=0.
- Fairness: after a release, the just-served requester has the lowest priority. Worst-case wait is (NUM_REQ-1) bursts.
- Widths: beat_cnt is $clog2(MAX_BURST+1) bits. rr_ptr and grant_idx use out_src width. Wrap is an explicit compare against NUM_REQ-1, not a power-of-2 overflow.
- Reset mid-burst: asynchronous return to reset state. A beat in flight is neither accepted nor counted. The FIFO's own reset covers any partial packet.
- grant_active is 1 exactly in BURST and changes only on clock edges.

Test Plan:
- Single requester: req 2 sends 3 beats 0xA0..0xA2 with last on 0xA2, out_ready=1 -> 1 idle cycle, then 3 consecutive out beats with out_src=2 and out_last on the third beat; back to IDLE; rr_ptr=3.
- Full contention: all 4 requesters send 2-beat bursts continuously from reset -> grant order 0,1,2,3,0; each burst is 1 idle cycle plus 2 beats; no interleaving of sources within a burst.
- Forced release: MAX_BURST=8, req 1 sends 10 beats with last only on beat 10 -> after beat 8, IDLE plus a burst_err pulse; the next grant goes to a waiting req 2 if present, otherwise req 1 resumes and sends beats 9 and 10 with no error.
- Backpressure: during a burst, out_ready toggles 1,0,0,1 -> req_ready mirrors it; exactly 2 beats are accepted; beat_cnt=2; out_data is stable while stalled.
- Wrap with NUM_REQ=3: req 2 is served, then req 0 and req 2 request together -> req 0 is granted (rr_ptr wrapped to 0).
- Reset mid-burst: assert rst_n=0 after beat 1 of 4 -> out_valid=0, req_ready=0 and grant_active=0 immediately. After release, the first grant starts search at index 0.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ ready/valid sources.
// One idle arbitration cycle per grant; out_ready backpressure passes straight to the granted requester.
module fifo_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [SRC_W-1:0]         out_src,
  output logic                     grant_active,
  output logic                     burst_err
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant_idx;
  logic [CNT_W-1:0]   beat_cnt;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic               busy;
  logic               accept;
  logic               release_c;
  logic               pick_vld;
  logic [SRC_W-1:0]   pick_idx;
  logic [SRC_W-1:0]   cand;
  logic [SRC_W-1:0]   next_ptr;
  int                 j;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    j        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = SRC_W'(j);
      if (req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign busy         = (state == BURST);
  assign grant_active = busy;
  assign out_valid    = busy & req_valid[grant_idx];
  assign out_data     = busy ? data_arr[grant_idx] : '0;
  assign out_last     = busy & req_last[grant_idx];
  assign out_src      = busy ? grant_idx : '0;

  assign accept    = out_valid & out_ready;
  assign release_c = accept & (req_last[grant_idx] | (beat_cnt == CNT_W'(MAX_BURST - 1)));
  assign next_ptr  = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_idx] = out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      burst_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_idx <= pick_idx;
            beat_cnt  <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (release_c) begin
            state     <= IDLE;
            rr_ptr    <= next_ptr;
            beat_cnt  <= '0;
            burst_err <= ~req_last[grant_idx];
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: scoreboarded requester queues, an arbitration vector table, and corner sequences.
module tb_fifo_rr_arbiter;
  localparam int N = 4, W = 32, SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready, req_last;
  logic [N*W-1:0] req_data;
  logic           out_valid, out_ready, out_last, grant_active, burst_err;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;

  fifo_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_last(req_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .grant_active(grant_active), .burst_err(burst_err));

  // Second instance: 3 requesters (non power of 2 wrap) with single-beat grants.
  logic [2:0]    r3_valid, r3_ready, r3_last;
  logic [3*W-1:0] r3_data;
  logic          o3_valid, o3_ready, o3_last, o3_ga, o3_err;
  logic [W-1:0]  o3_data;
  logic [1:0]    o3_src;

  fifo_rr_arbiter #(.NUM_REQ(3), .WIDTH(W), .MAX_BURST(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_data(r3_data), .req_last(r3_last), .out_valid(o3_valid),
    .out_ready(o3_ready), .out_data(o3_data), .out_last(o3_last),
    .out_src(o3_src), .grant_active(o3_ga), .burst_err(o3_err));

  typedef struct packed {
    logic [SW-1:0] src;
    logic [W-1:0]  data;
    logic          last;
  } beat_t;

  typedef struct {
    int         prev;
    logic [3:0] mask;
    logic [15:0] order;
    int         cnt;
  } vec_t;

  beat_t        exp_q[$];
  int           acc_cyc[$];
  int           err_cyc[$];
  logic [W-1:0] bdat  [N][32];
  logic         blast [N][32];
  int           bn[N], bp[N];
  int           checks = 0, errors = 0, cyc = 0;
  logic [N-1:0] smp_rdy;
  logic [W-1:0] smp_dat;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic add_beat(int r, logic [W-1:0] d, logic l);
    bdat[r][bn[r]]  = d;
    blast[r][bn[r]] = l;
    bn[r]++;
  endtask

  task automatic add_burst(int r, int len, logic last_flag);
    for (int k = 0; k < len; k++)
      add_beat(r, {16'hD0D0, 8'(r), 8'(bn[r])}, last_flag && (k == len - 1));
  endtask

  task automatic exp_push(int r, int k);
    beat_t b;
    b.src  = SW'(r);
    b.data = bdat[r][k];
    b.last = blast[r][k];
    exp_q.push_back(b);
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (bp[i] < bn[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = bdat[i][bp[i]];
        req_last[i]        = blast[i][bp[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic step();
    beat_t e;
    apply_inputs();
    @(negedge clk);
    smp_rdy = req_ready;
    smp_dat = out_data;
    if (out_valid && out_ready) begin
      acc_cyc.push_back(cyc);
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 64'({out_src, out_data, out_last}), 64'(e));
      end
    end
    if (burst_err) err_cyc.push_back(cyc);
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) bp[i]++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(int budget);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (exp_q.size() == 0) && !grant_active;
      for (int i = 0; i < N; i++) if (bp[i] != bn[i]) done = 1'b0;
    end
    check("drain_done", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin bn[i] = 0; bp[i] = 0; end
    exp_q.delete();
    acc_cyc.delete();
    err_cyc.delete();
    out_ready = 1'b1;
    apply_inputs();
    r3_valid = '0; r3_last = '0; r3_data = '0; o3_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];
  logic rdy_pat[4];
  int   c0, bad, src;

  initial begin
    vecs[0] = '{prev: 3, mask: 4'b1111, order: 16'h3210, cnt: 4};
    vecs[1] = '{prev: 0, mask: 4'b1111, order: 16'h0321, cnt: 4};
    vecs[2] = '{prev: 1, mask: 4'b1101, order: 16'h0032, cnt: 3};
    vecs[3] = '{prev: 2, mask: 4'b0101, order: 16'h0020, cnt: 2};
    vecs[4] = '{prev: 3, mask: 4'b1000, order: 16'h0003, cnt: 1};
    vecs[5] = '{prev: 2, mask: 4'b0110, order: 16'h0021, cnt: 2};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    check("reset_outputs", 64'({out_valid, req_ready, grant_active, burst_err, out_src, out_data, out_last}), 64'd0);
    check("reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);

    // Single requester, 3-beat burst
    add_beat(2, 32'hA0, 1'b0); add_beat(2, 32'hA1, 1'b0); add_beat(2, 32'hA2, 1'b1);
    for (int k = 0; k < 3; k++) exp_push(2, k);
    c0 = cyc;
    drain(20);
    check("single_beats", 64'(acc_cyc.size()), 64'd3);
    for (int k = 0; k < 3 && k < acc_cyc.size(); k++)
      check("single_cyc", 64'(acc_cyc[k] - c0), 64'(k + 1));
    check("single_rr_ptr", 64'(dut.rr_ptr), 64'd3);

    // Arbitration vector table: serve prev first, then offer mask
    for (int v = 0; v < 6; v++) begin
      do_reset();
      add_burst(vecs[v].prev, 1, 1'b1);
      exp_push(vecs[v].prev, 0);
      drain(20);
      for (int i = 0; i < N; i++) if (vecs[v].mask[i]) add_burst(i, 1, 1'b1);
      for (int k = 0; k < vecs[v].cnt; k++) begin
        src = int'(vecs[v].order[k*4 +: 4]);
        exp_push(src, bn[src] - 1);
      end
      drain(40);
    end

    // Full contention from reset, two 2-beat bursts per requester
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < N; r++) add_burst(r, 2, 1'b1);
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < N; r++)
        for (int k = 0; k < 2; k++) exp_push(r, rep*2 + k);
    c0 = cyc;
    drain(80);
    check("contention_beats", 64'(acc_cyc.size()), 64'd16);
    bad = 0;
    for (int k = 0; k < acc_cyc.size(); k++)
      if (acc_cyc[k] - c0 != (k/2)*3 + (k%2) + 1) bad++;
    check("contention_timing", 64'(bad), 64'd0);

    // Forced release, requester 1 alone
    do_reset();
    add_burst(1, 10, 1'b1);
    for (int k = 0; k < 10; k++) exp_push(1, k);
    c0 = cyc;
    drain(40);
    check("force_err_count", 64'(err_cyc.size()), 64'd1);
    if (err_cyc.size() > 0) check("force_err_cyc", 64'(err_cyc[0] - c0), 64'd9);
    if (acc_cyc.size() > 8) check("force_resume_cyc", 64'(acc_cyc[8] - c0), 64'd10);

    // Forced release with requester 2 waiting
    do_reset();
    add_burst(1, 10, 1'b1);
    add_burst(2, 1, 1'b1);
    for (int k = 0; k < 8; k++) exp_push(1, k);
    exp_push(2, 0);
    exp_push(1, 8); exp_push(1, 9);
    drain(40);
    check("force_wait_err_count", 64'(err_cyc.size()), 64'd1);

    // Backpressure pattern 1,0,0,1
    do_reset();
    add_burst(0, 4, 1'b1);
    for (int k = 0; k < 4; k++) exp_push(0, k);
    step();
    for (int t = 0; t < 4; t++) begin
      out_ready = rdy_pat[t];
      step();
      check("bp_ready", 64'(smp_rdy), 64'({3'b000, rdy_pat[t]}));
      if (t == 1 || t == 2) check("bp_stable", 64'(smp_dat), 64'(bdat[0][1]));
    end
    check("bp_beat_cnt", 64'(dut.beat_cnt), 64'd2);
    out_ready = 1'b1;
    drain(20);

    // Reset mid-burst
    do_reset();
    add_burst(3, 4, 1'b1);
    for (int k = 0; k < 4; k++) exp_push(3, k);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({out_valid, req_ready, grant_active}), 64'd0);
    do_reset();
    add_burst(3, 1, 1'b1);
    add_burst(1, 1, 1'b1);
    exp_push(1, 0);
    exp_push(3, 0);
    drain(20);

    // NUM_REQ=3 wrap and MAX_BURST=1
    do_reset();
    r3_valid = 3'b100; r3_last = 3'b100; r3_data = {32'hC2, 32'h0, 32'h0};
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_first", 64'({o3_valid, o3_src}), 64'({1'b1, 2'd2}));
    @(posedge clk); #1;
    r3_valid = 3'b101; r3_last = 3'b100; r3_data = {32'hC2, 32'h0, 32'hC0};
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_second", 64'({o3_valid, o3_src, o3_data}), 64'({1'b1, 2'd0, 32'hC0}));
    @(posedge clk); #1;
    r3_valid = 3'b100;
    @(negedge clk);
    check("mb1_err_pulse", 64'(o3_err), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mb1_last_no_err", 64'({o3_err, o3_valid, o3_src}), 64'({1'b0, 1'b1, 2'd2}));
    @(posedge clk); #1;
    r3_valid = 3'b000;
    @(negedge clk);
    check("mb1_last_err_low", 64'(o3_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
